// File: rtl/memory_tester_pkg.sv
// rtl/memory_tester_pkg.sv - shared helpers for the memory tester RAM window
package memory_tester_pkg;

    localparam int MAX_IMAGE_W = 8192;
    localparam int MAX_WORD_W  = 256;

    // Index width for an array of n words, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Extract entry j of a packed reference image whose entries are w bits wide.
    function automatic logic [MAX_WORD_W-1:0] unpack_entry(
        input logic [MAX_IMAGE_W-1:0] image,
        input int                     j,
        input int                     w
    );
        logic [MAX_IMAGE_W-1:0] shifted;
        logic [MAX_WORD_W-1:0]  entry;
        shifted = image >> (j * w);
        entry   = shifted[MAX_WORD_W-1:0];
        for (int b = 0; b < MAX_WORD_W; b++) begin
            if (b >= w) entry[b] = 1'b0;
        end
        return entry;
    endfunction

endpackage

// File: rtl/memory_tester_ram_if.sv
// rtl/memory_tester_ram_if.sv - word bus between a CPU-side master and the tester window
interface memory_tester_ram_if #(
    parameter int addr_size = 30,
    parameter int word_size = 32
);
    logic [addr_size-1:0] addr;
    logic [word_size-1:0] data_in;
    logic                 write_en;
    logic [word_size-1:0] data_out;

    modport master (output addr, output data_in, output write_en, input data_out);
    modport slave  (input addr, input data_in, input write_en, output data_out);
endinterface

// File: rtl/memory_tester_decode.sv
// rtl/memory_tester_decode.sv - window select and entry index from the word address
module memory_tester_decode #(
    parameter int base_addr  = 1024,
    parameter int addr_size  = 30,
    parameter int array_size = 4,
    parameter int idx_w      = 2
) (
    input  logic [addr_size-1:0] addr_i,
    output logic                 sel_o,
    output logic [idx_w-1:0]     idx_o
);
    // One extra bit so the window end is representable and overflow is visible.
    localparam logic [addr_size:0] BASE_X = (addr_size + 1)'(base_addr);
    localparam logic [addr_size:0] END_X  = BASE_X + (addr_size + 1)'(array_size);
    localparam logic [addr_size:0] LIMIT  = {1'b1, {addr_size{1'b0}}};

    if (END_X > LIMIT) begin : g_bad_window
        $error("memory_tester_decode: base_addr + array_size overflows addr_size bits");
    end

    logic [addr_size:0] addr_x;
    assign addr_x = {1'b0, addr_i};
    assign sel_o  = (addr_x >= BASE_X) && (addr_x < END_X);
    assign idx_o  = idx_w'(addr_i - BASE_X[addr_size-1:0]);

endmodule

// File: rtl/memory_tester_ram.sv
// rtl/memory_tester_ram.sv - self-checking RAM window compared against a reference image
// Read path built only when MEMORY_TESTER_READBACK_EN is defined; otherwise data_out is 0.
module memory_tester_ram
    import memory_tester_pkg::*;
#(
    parameter int                            base_addr     = 1024,
    parameter int                            addr_size     = 30,
    parameter int                            array_size    = 4,
    parameter int                            word_size     = 32,
    parameter logic [array_size*word_size-1:0] array_content = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    memory_tester_ram_if.slave   bus,
    output logic                 content_ok
);
    localparam int IDX_W = idx_width(array_size);
    localparam logic [MAX_IMAGE_W-1:0] IMG = MAX_IMAGE_W'(array_content);

    logic             sel;
    logic [IDX_W-1:0] idx;

    memory_tester_decode #(
        .base_addr  (base_addr),
        .addr_size  (addr_size),
        .array_size (array_size),
        .idx_w      (IDX_W)
    ) u_decode (
        .addr_i (bus.addr),
        .sel_o  (sel),
        .idx_o  (idx)
    );

    logic [word_size-1:0] mem_q [array_size];
    logic [word_size-1:0] mem_d [array_size];

    always_comb begin
        mem_d = mem_q;
        if (bus.write_en && sel) mem_d[idx] = bus.data_in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int j = 0; j < array_size; j++) mem_q[j] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

`ifdef MEMORY_TESTER_READBACK_EN
    // Reads sample mem_q, so a same-edge write returns the pre-write word.
    logic [word_size-1:0] rdata_q;
    logic [word_size-1:0] rdata_d;

    assign rdata_d = sel ? mem_q[idx] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rdata_q <= '0;
        else        rdata_q <= rdata_d;
    end

    assign bus.data_out = rdata_q;
`else
    assign bus.data_out = '0;
`endif

    logic [array_size-1:0] match;

    for (genvar j = 0; j < array_size; j++) begin : g_cmp
        localparam logic [word_size-1:0] REF_J = word_size'(unpack_entry(IMG, j, word_size));
        assign match[j] = (mem_q[j] == REF_J);
    end

    assign content_ok = &match;

endmodule

// File: tb/tb_memory_tester_ram.sv
// tb/tb_memory_tester_ram.sv - randomized self-checking bench with a behavioural memory model
module tb_memory_tester_ram;

    localparam logic [127:0] IMAGE = 128'h0D0C0B0A_0304EF00_01020304_ABCDEF00;
`ifdef MEMORY_TESTER_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic clk;
    logic reset;
    logic content_ok;

    memory_tester_ram_if #(.addr_size(30), .word_size(32)) bus ();

    memory_tester_ram #(
        .base_addr     (1024),
        .addr_size     (30),
        .array_size    (4),
        .word_size     (32),
        .array_content (IMAGE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .content_ok (content_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned ref_word [4] = '{32'hABCDEF00, 32'h01020304, 32'h0304EF00, 32'h0D0C0B0A};
    int unsigned model    [4];
    int unsigned exp_dout;
    int checks;
    int errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic bit model_ok();
        for (int j = 0; j < 4; j++) if (model[j] != ref_word[j]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check_mem(input string tag);
        for (int j = 0; j < 4; j++)
            check($sformatf("%s_mem%0d", tag, j), dut.mem_q[j], model[j]);
    endtask

    // Drive one access from a negedge, apply the model at the posedge, check at the next negedge.
    task automatic cycle(input string tag, input int unsigned a, input int unsigned d, input bit w);
        bit in_win;
        int unsigned i;
        bus.addr     = a[29:0];
        bus.data_in  = d;
        bus.write_en = w;
        @(posedge clk);
        in_win   = (a >= 1024) && (a < 1028);
        i        = a - 1024;
        exp_dout = (in_win && RB) ? model[i[1:0]] : 0;
        if (w && in_win) model[i[1:0]] = d;
        @(negedge clk);
        check({tag, "_dout"}, bus.data_out, exp_dout);
        check({tag, "_ok"}, {31'b0, content_ok}, {31'b0, model_ok()});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        for (int j = 0; j < 4; j++) model[j] = 0;
        reset        = 1'b0;
        bus.addr     = '0;
        bus.data_in  = '0;
        bus.write_en = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dout", bus.data_out, 32'h0);
        check("rst_ok", {31'b0, content_ok}, 32'h0);
        check_mem("rst");
        reset = 1'b1;

        for (int j = 0; j < 4; j++) cycle($sformatf("wr%0d", j), 1024 + j, ref_word[j], 1'b1);
        check("ok_after_fill", {31'b0, content_ok}, 32'h1);
        cycle("spoil", 1025, 32'h01020305, 1'b1);
        check("ok_after_spoil", {31'b0, content_ok}, 32'h0);
        cycle("restore", 1025, 32'h01020304, 1'b1);

        cycle("wr_below", 1023, 32'hDEADBEEF, 1'b1);
        cycle("wr_above", 1028, 32'hDEADBEEF, 1'b1);
        cycle("rd_below", 1023, 0, 1'b0);
        cycle("rd_above", 1028, 0, 1'b0);
        check_mem("outside");

        cycle("rd1026", 1026, 0, 1'b0);
        check("rd1026_val", bus.data_out, RB ? 32'h0304EF00 : 32'h0);
        cycle("rw1026", 1026, 32'h11111111, 1'b1);
        check("rw1026_old", bus.data_out, RB ? 32'h0304EF00 : 32'h0);
        cycle("rd1026_new", 1026, 0, 1'b0);
        check("rd1026_new_val", bus.data_out, RB ? 32'h11111111 : 32'h0);

        for (int n = 0; n < 300; n++) begin
            int unsigned a;
            int unsigned d;
            a = 1020 + $urandom_range(0, 11);
            d = ($urandom_range(0, 1) == 1) ? ref_word[(a - 1020) % 4] : $urandom;
            cycle("rnd", a, d, $urandom_range(0, 1) == 1);
            if (n % 50 == 0) check_mem("rnd");
        end

        for (int j = 0; j < 4; j++) cycle("refill", 1024 + j, ref_word[j], 1'b1);
        cycle("refill_rd", 1027, 0, 1'b0);
        check("pre_reset_ok", {31'b0, content_ok}, 32'h1);
        #2;
        reset = 1'b0;
        for (int j = 0; j < 4; j++) model[j] = 0;
        #1;
        check("async_dout", bus.data_out, 32'h0);
        check("async_ok", {31'b0, content_ok}, 32'h0);
        check_mem("async");
        @(negedge clk);
        reset = 1'b1;
        cycle("post_rst", 1024, ref_word[0], 1'b1);
        check_mem("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_tester_ram.md
# memory_tester_ram

Self-checking word-addressed RAM window for CPU-level testbenches. It maps a small array of words at a fixed word address, so the CPU under test can write and read it like normal memory. It continuously compares the array against a compile-time reference image and flags a full match on `content_ok`. It shares the data bus with other slaves by OR-ing, so it drives zero when not addressed.

## Interface
- `base_addr`, default 1024: word address of array entry 0.
- `addr_size`, default 30: width of the word address bus.
- `array_size`, default 4: number of words in the array (≥1).
- `word_size`, default 32: data width.
- `array_content`, default 0 (`array_size*word_size` bits): packed reference image. Entry j = `array_content[j*word_size +: word_size]`, so entry 0 sits in the LSBs.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low.
- `addr` input `addr_size`: word address.
- `data_in` input `word_size`: write data.
- `write_en` input 1: write strobe.
- `data_out` output `word_size`: read data; zero when not selected.
- `content_ok` output 1: high when every array word equals its reference entry.

## Operation
- Select: `sel = (addr >= base_addr) && (addr < base_addr + array_size)`.
  - Compare unsigned at `addr_size` width.
  - `base_addr + array_size` must not overflow `addr_size` bits; this is a parameter constraint, checked at elaboration.
- Index: `idx = addr - base_addr`, truncated to `$clog2(array_size)` bits (minimum 1).
- Write: on a rising edge with `write_en && sel`, `mem[idx] <= data_in`. Full-word writes only, no byte enables. Writes outside the window are ignored.
- Read:
  - `data_out` is registered.
  - On each rising edge it becomes `mem[idx]` if `sel`, else 0.
  - Reads are driven whether or not `write_en` is asserted.
- Same-address read and write on one edge: `data_out` returns the old (pre-write) value.
- Compare:
  - `content_ok` is combinational: AND over j of `(mem[j] == ref[j])`.
  - `ref[j]` is the constant slice of `array_content`.
- Reset (`reset` low, asynchronous):
  - all `mem[j]` cleared to 0;
  - `data_out` cleared to 0;
  - `content_ok` therefore equals `(array_content == 0)`.
- Reset asserted mid-operation: in-flight writes are lost and the array returns to zeros immediately.
- X/undriven `addr` is treated as not selected only to the extent the simulator resolves it; no special handling is defined.

## Timing
- Write latency: 1 cycle. `mem` updates on the edge where `write_en && sel`.
- `content_ok` reflects that write combinationally after the same edge.
- Read latency: 1 cycle. Address presented in cycle N gives `data_out` valid after edge N+1.
- No handshake, always ready; back-to-back accesses every cycle.
- On release of `reset`, the first edge performs a normal access.

## Configuration
- `MEMORY_TESTER_READBACK_EN`:
  - Defined: read path as specified above.
  - Undefined: `data_out` tied to 0 (write-only checker); the read register is not built.
- Write and compare behaviour are identical in both builds.

## Structure
- Shared package `memory_tester_pkg` holds:
  - the index-width helper function (clog2 with minimum 1);
  - the unpack function that extracts reference entry j from `array_content`.
- One natural sub-module, `memory_tester_decode`: the range select and index generation from `addr`, `base_addr` and `array_size`.
- The storage array, read register and comparator stay in the top module.

## Test plan
All scenarios use the default parameters with `array_content = 128'h0D0C0B0A_0304EF00_01020304_ABCDEF00`, giving ref[0..3] = `ABCDEF00`, `01020304`, `0304EF00`, `0D0C0B0A`.

1. Reset low, then released → `data_out` = 0, `content_ok` = 0, all four mem words = 0.
2. Write the four reference words to addresses 1024–1027, one per cycle → `content_ok` rises after the 4th write edge. Then rewrite addr 1025 with `01020305` → `content_ok` falls after that edge.
3. Write `DEADBEEF` to addr 1023 and to addr 1028 → mem unchanged, `content_ok` unchanged. Reads of those addresses give `data_out` = 0.
4. Read addr 1026 after the scenario-2 writes → `data_out` = `0304EF00` one cycle later. Write `11111111` and read addr 1026 on the same edge → `data_out` = `0304EF00`, and the next read returns `11111111`.
5. Assert `reset` low asynchronously mid-cycle after `content_ok` = 1 → mem and `data_out` are 0 immediately and `content_ok` = 0 without waiting for a clock edge.
6. Build without `MEMORY_TESTER_READBACK_EN` and repeat scenario 2 with reads interleaved → `data_out` stays 0 throughout, and `content_ok` behaves exactly as in scenario 2.
